// File: rtl/buffer_arbiter.sv
// rtl/buffer_arbiter.sv - two-port round-robin push/pop sequencer for the LIFO stack buffer
// Tracks occupancy itself so illegal ops are rejected before they reach the buffer.
module buffer_arbiter #(
  parameter int DEPTH = 11,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             err0,
  output logic             err1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             sync_err,
  output logic             buf_write,
  output logic             buf_read,
  output logic [WIDTH-1:0] buf_wdata,
  input  logic [WIDTH-1:0] buf_rdata,
  input  logic             buf_full,
  input  logic             buf_empty
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, REJECT} state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             last_q, last_d;
  logic [CW-1:0]    count_q, count_d;
  logic             sync_err_q, sync_err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             pick1;
  logic             pick_op;
  logic             illegal;
  logic             flag_mismatch;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    last_d     = last_q;
    count_d    = count_q;
    sync_err_d = sync_err_q;
    rdata_d    = rdata_q;

    // On a tie the requester not served last wins; last resets to 1 so req0 wins first.
    pick1   = req1 & (~req0 | ~last_q);
    pick_op = pick1 ? op1 : op0;
    illegal = pick_op ? (count_q == FULL_CNT) : (count_q == '0);
    flag_mismatch = (buf_empty != (count_q == '0)) || (buf_full != (count_q == FULL_CNT));

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d = pick1;
          if (illegal) begin
            state_d = REJECT;
          end else begin
            op_d    = pick_op;
            wdata_d = pick1 ? wdata1 : wdata0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (op_q && count_q != FULL_CNT) begin
          count_d = count_q + CW'(1);
        end else if (!op_q && count_q != '0) begin
          count_d = count_q - CW'(1);
        end
        state_d = DONE;
      end
      DONE: begin
        if (!op_q) begin
          rdata_d = buf_rdata;
        end
        if (flag_mismatch) begin
          sync_err_d = 1'b1;
        end
        last_d  = sel_q;
        state_d = IDLE;
      end
      REJECT: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      op_q       <= 1'b0;
      wdata_q    <= '0;
      last_q     <= 1'b1;
      count_q    <= '0;
      sync_err_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      last_q     <= last_d;
      count_q    <= count_d;
      sync_err_q <= sync_err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign buf_write = (state_q == ISSUE) &&  op_q;
  assign buf_read  = (state_q == ISSUE) && !op_q;
  assign buf_wdata = buf_write ? wdata_q : '0;
  assign count     = count_q;

  assign gnt0    = (state_q == DONE) && !sel_q;
  assign gnt1    = (state_q == DONE) &&  sel_q;
  assign rvalid0 = gnt0 && !op_q;
  assign rvalid1 = gnt1 && !op_q;
  assign err0    = (state_q == REJECT) && !sel_q;
  assign err1    = (state_q == REJECT) &&  sel_q;

  // Pop data and a flag mismatch are both visible during DONE itself, then held.
  assign rdata    = ((state_q == DONE) && !op_q) ? buf_rdata : rdata_q;
  assign sync_err = sync_err_q || ((state_q == DONE) && flag_mismatch);

endmodule

// File: tb/tb_buffer_arbiter.sv
// tb/tb_buffer_arbiter.sv - directed bench for buffer_arbiter with a LIFO buffer model
module tb_buffer_arbiter;
  localparam int DEPTH = 11;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic             gnt0, gnt1, err0, err1, rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata;
  logic [CW-1:0]    count;
  logic             busy, sync_err, buf_write, buf_read;
  logic [WIDTH-1:0] buf_wdata, buf_rdata;
  logic             buf_full, buf_empty;
  logic             tie_nempty = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  buffer_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .count(count), .busy(busy), .sync_err(sync_err),
    .buf_write(buf_write), .buf_read(buf_read), .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata), .buf_full(buf_full), .buf_empty(buf_empty)
  );

  // LIFO buffer model with registered data_out, sharing the arbiter reset
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  int               sp;
  logic [WIDTH-1:0] dout;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp   <= 0;
      dout <= '0;
    end else if (buf_write && sp < DEPTH) begin
      mem[sp] <= buf_wdata;
      sp      <= sp + 1;
    end else if (buf_read && sp > 0) begin
      dout <= mem[sp-1];
      sp   <= sp - 1;
    end
  end

  assign buf_rdata = dout;
  assign buf_full  = (sp == DEPTH);
  assign buf_empty = (sp == 0) && !tie_nempty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    tie_nempty = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One request from one requester, checked cycle by cycle until IDLE again.
  task automatic do_req(input int who, input logic op, input logic [7:0] data,
                        input logic exp_err, input logic [7:0] exp_rd,
                        input logic [3:0] exp_cnt, input logic exp_sync);
    if (who == 0) begin
      req0 = 1'b1; op0 = op; wdata0 = data;
    end else begin
      req1 = 1'b1; op1 = op; wdata1 = data;
    end
    @(negedge clk);
    if (exp_err) begin
      check("err", (who == 0) ? err0 : err1, 1);
      check("err_no_strobe", {buf_write, buf_read}, 0);
    end else begin
      check("strobe_write", buf_write, op);
      check("strobe_read", buf_read, !op);
      if (op) check("buf_wdata", buf_wdata, data);
      @(negedge clk);
      check("gnt", (who == 0) ? gnt0 : gnt1, 1);
      check("rvalid", (who == 0) ? rvalid0 : rvalid1, !op);
    end
    check("rdata", rdata, exp_rd);
    check("count", count, exp_cnt);
    check("sync_err", sync_err, exp_sync);
    if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    check("back_idle", busy, 0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {buf_write, buf_read, gnt0, gnt1, err0, err1}, 0);
    rst = 1'b1;
    @(negedge clk);

    // single push, then pop it back
    do_req(0, 1'b1, 8'hA5, 1'b0, 8'h00, 4'd1, 1'b0);
    do_req(0, 1'b0, 8'h00, 1'b0, 8'hA5, 4'd0, 1'b0);

    // LIFO ordering across requesters
    do_req(1, 1'b1, 8'h11, 1'b0, 8'hA5, 4'd1, 1'b0);
    do_req(1, 1'b1, 8'h22, 1'b0, 8'hA5, 4'd2, 1'b0);
    do_req(1, 1'b1, 8'h33, 1'b0, 8'hA5, 4'd3, 1'b0);
    do_req(0, 1'b0, 8'h00, 1'b0, 8'h33, 4'd2, 1'b0);
    do_req(0, 1'b0, 8'h00, 1'b0, 8'h22, 4'd1, 1'b0);
    do_req(0, 1'b0, 8'h00, 1'b0, 8'h11, 4'd0, 1'b0);

    // pop on empty is rejected, rdata holds
    do_req(1, 1'b0, 8'h00, 1'b1, 8'h11, 4'd0, 1'b0);

    // both requesters pushing from reset: alternate until full, then reject
    do_reset();
    req0 = 1'b1; op0 = 1'b1; wdata0 = 8'h40;
    req1 = 1'b1; op1 = 1'b1; wdata1 = 8'h80;
    for (int i = 0; i < 12; i++) begin
      int got;
      got = -1;
      for (int c = 0; c < 6 && got < 0; c++) begin
        @(negedge clk);
        if (i == 11) check("full_no_write", buf_write, 0);
        if (gnt0) got = 0;
        else if (gnt1) got = 1;
        else if (err0) got = 2;
        else if (err1) got = 3;
      end
      check($sformatf("tie_turn_%0d", i), got, (i == 11) ? 3 : (i % 2));
    end
    check("full_count", count, 11);
    check("full_flag", buf_full, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);

    // reset during the ISSUE cycle of a push
    do_reset();
    do_req(0, 1'b1, 8'h77, 1'b0, 8'h00, 4'd1, 1'b0);
    req0 = 1'b1; op0 = 1'b1; wdata0 = 8'h88;
    @(negedge clk);
    check("issue_write", buf_write, 1);
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    check("midrst_write", buf_write, 0);
    check("midrst_wdata", buf_wdata, 0);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(0, 1'b0, 8'h00, 1'b1, 8'h00, 4'd0, 1'b0);

    // buffer claims non-empty when count is zero
    do_reset();
    tie_nempty = 1'b1;
    do_req(0, 1'b1, 8'h5A, 1'b0, 8'h00, 4'd1, 1'b0);
    do_req(1, 1'b0, 8'h00, 1'b0, 8'h5A, 4'd0, 1'b1);
    tie_nempty = 1'b0;
    repeat (3) @(negedge clk);
    check("sync_sticky", sync_err, 1);
    do_reset();
    check("sync_cleared", sync_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/buffer_arbiter.md
# buffer_arbiter

Two-port round-robin arbiter and sequencer for the 8-bit LIFO stack buffer. Two requesters each submit push or pop requests. The arbiter serialises them onto the buffer's single write/read strobe pair and tracks occupancy internally, so illegal operations are rejected before they reach the buffer. It returns per-requester completion, pop data and error pulses, and flags any disagreement between its occupancy count and the buffer's full/empty flags.

## Interface
- DEPTH, 11, buffer capacity in entries
- WIDTH, 8, data width
- CW, $clog2(DEPTH+1), occupancy count width (4 at default)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req0, req1  in  1  level request; held until the matching gnt or err pulse
- op0, op1  in  1  1 = push (write), 0 = pop (read); stable while req is high
- wdata0, wdata1  in  WIDTH  push data; stable while req is high
- gnt0, gnt1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle rejection pulse (push when full, pop when empty)
- rvalid0, rvalid1  out  1  one-cycle pop-data-valid pulse, coincident with gnt of a pop
- rdata  out  WIDTH  popped data, held until the next pop completes
- count  out  CW  current occupancy, 0..DEPTH
- busy  out  1  high whenever the state is not IDLE
- sync_err  out  1  sticky flag: buffer flags disagreed with count
- buf_write, buf_read  out  1  one-cycle strobes to the buffer
- buf_wdata  out  WIDTH  data to the buffer
- buf_rdata  in  WIDTH  buffer data_out
- buf_full, buf_empty  in  1  buffer status flags

## Operation
- States are IDLE, ISSUE, DONE and REJECT.
- IDLE with no requests: stay in IDLE.
- IDLE with exactly one request: select that requester.
- IDLE with both requests: select the requester not served last. The `last` pointer resets to 1, so req0 wins the first tie.
- Legality check in IDLE uses `count`, not the buffer flags:
  - A push is illegal when count == DEPTH.
  - A pop is illegal when count == 0.
- Legal selection: latch the requester index, op and wdata, then go to ISSUE.
- Illegal selection: go to REJECT.
- ISSUE:
  - Assert buf_write (push) or buf_read (pop) for exactly one cycle, with buf_wdata = latched data.
  - Update count by +1 or -1 at the end of this cycle.
  - Go to DONE.
- DONE:
  - Pulse gnt of the selected requester.
  - For a pop, capture buf_rdata into rdata and pulse rvalid.
  - Compare the buffer flags with count: buf_empty must equal (count == 0) and buf_full must equal (count == DEPTH). On a mismatch, set sync_err.
  - Set `last` to the served requester and go to IDLE.
- REJECT:
  - Pulse err of the selected requester.
  - Set `last` to that requester, so a rejection consumes its turn.
  - Go to IDLE.
- At most one strobe is active in any cycle. buf_write and buf_read are never high together.
- count saturates in logic: it never exceeds DEPTH and never goes below 0, which the legality check guarantees.
- sync_err clears only on reset.
- rdata is unchanged by pushes and by rejections.

## Timing
- A request seen high in IDLE at edge N produces:
  - Legal op: strobe in cycle N+1, gnt/rvalid in cycle N+2, IDLE again in cycle N+3.
  - Illegal op: err in cycle N+1, IDLE again in cycle N+2.
- Throughput is one legal op per 3 cycles and one rejection per 2 cycles.
- A requester may drop req in the cycle after its gnt/err. If req is still high in IDLE, it is treated as a new request.
- Requests are sampled only in IDLE. Changes to req, op or wdata during ISSUE, DONE or REJECT are ignored.
- Reset asserted, at any time including mid-operation, forces all of the following immediately:
  - state = IDLE and last = 1
  - count = 0, sync_err = 0, rdata = 0
  - gnt, err, rvalid = 0
  - buf_write, buf_read = 0, buf_wdata = 0
  - busy = 0
- The buffer must share the same reset so that count = 0 matches an empty buffer.
- Reset release takes effect at the first rising edge with rst = 1.

## Test plan
- Reset, then req0 push 0xA5: buf_write high in cycle 1 with buf_wdata = 0xA5, gnt0 in cycle 2, count = 1, rdata = 0x00.
- Push 0x11, 0x22, 0x33 from req1, then pop three times from req0: rdata sequence 0x33, 0x22, 0x11 with rvalid0 each time, and count ends at 0.
- req0 and req1 both held as pushes from reset: grants alternate 0,1,0,1; after 11 pushes count = 11 and buf_full = 1; the 12th request gets err instead of gnt and buf_write stays low.
- Pop from req1 with count = 0: err1 pulses one cycle after the request, no buf_read strobe, count stays 0, and rdata is unchanged.
- Drive rst low during the ISSUE cycle of a push: buf_write drops immediately, count = 0 and busy = 0; after release, a pop gets err.
- Tie buf_empty to 0 with count = 0 after a push/pop pair: sync_err rises in DONE of the pop and stays high until reset.
